// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// servo_pwm_decoder: measures servo PWM high time, returns 12-bit angle | Rev 1.0
// ---------------------------------------------------------------------------
module servo_pwm_decoder #(
  parameter int TICKDIV  = 488,
  parameter int SERVOMIN = 124,
  parameter int SERVOMAX = 543,
  parameter int REVERSED = 0,
  parameter int TIMEOUT  = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [11:0] angle,
  output logic        valid,
  output logic        lost,
  output logic        overrange
);

  localparam int          TW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam int          OW      = $clog2(TIMEOUT + 1);
  localparam logic [11:0] SMIN    = 12'(SERVOMIN);
  localparam logic [11:0] SMAX    = 12'(SERVOMAX);
  localparam logic [12:0] DIVISOR = 13'(SERVOMAX - SERVOMIN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    MEASURE = 3'd2,
    DIVIDE  = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  state_t          state;
  logic            sync1, sync2, level, rise, fall;
  logic [1:0]      fill;
  logic [TW-1:0]   tick_cnt;
  logic [OW-1:0]   to_cnt;
  logic            tick, to_hit;
  logic [11:0]     width, width_inc, rem, dq, quotient;
  logic [3:0]      step;
  logic            clamp_lo, clamp_hi;
  logic [20:0]     dividend;
  logic [12:0]     trial;

  // fill keeps IDLE from trusting the synchroniser until its reset zeros have flushed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      fill  <= 2'd0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      level <= sync2;
      rise  <= sync2 & ~level;
      fall  <= ~sync2 & level;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign tick   = (tick_cnt == TW'(TICKDIV - 1));
  assign to_hit = enable && !rise && tick && (to_cnt == OW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      to_cnt   <= '0;
    end else if (!enable || rise) begin
      tick_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick && to_cnt != OW'(TIMEOUT)) to_cnt <= to_cnt + OW'(1);
    end
  end

  // The tick landing on the falling-edge clock is still part of the pulse
  assign width_inc = (tick && width != 12'hFFF) ? width + 12'd1 : width;
  assign dividend  = (width_inc > SMIN) ? 21'(width_inc - SMIN) * 21'd4095 : 21'd0;
  assign trial     = {rem, dq[11]};
  assign quotient  = clamp_hi ? 12'hFFF : dq;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      width     <= 12'd0;
      rem       <= 12'd0;
      dq        <= 12'd0;
      step      <= 4'd0;
      clamp_lo  <= 1'b0;
      clamp_hi  <= 1'b0;
      angle     <= 12'd0;
      valid     <= 1'b0;
      lost      <= 1'b0;
      overrange <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        width <= 12'd0;
        rem   <= 12'd0;
        dq    <= 12'd0;
        step  <= 4'd0;
      end else if (to_hit) begin
        state <= IDLE;
        lost  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fill == 2'd3 && !sync2 && !level) state <= ARMED;
          end
          ARMED: begin
            if (rise) begin
              width <= 12'd0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            width <= width_inc;
            if (fall) begin
              // Remainder starts with the dividend bits above the 12 quotient bits
              rem      <= {3'b000, dividend[20:12]};
              dq       <= dividend[11:0];
              step     <= 4'd0;
              clamp_lo <= (width_inc <= SMIN);
              clamp_hi <= (width_inc >= SMAX);
              state    <= DIVIDE;
            end
          end
          DIVIDE: begin
            if (trial >= DIVISOR) begin
              rem <= 12'(trial - DIVISOR);
              dq  <= {dq[10:0], 1'b1};
            end else begin
              rem <= trial[11:0];
              dq  <= {dq[10:0], 1'b0};
            end
            step <= step + 4'd1;
            if (step == 4'd11) state <= OUTPUT;
          end
          OUTPUT: begin
            angle     <= (REVERSED != 0) ? 12'd4095 - quotient : quotient;
            overrange <= clamp_lo | clamp_hi;
            valid     <= 1'b1;
            lost      <= 1'b0;
            state     <= ARMED;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Measures the high time of an incoming servo-style PWM pulse and converts it back to the 12-bit angle code used by the servo PWM generator.
- Sits on the receive side of the servo interface, for loop-back checking of the actuator path and for capturing external RC/servo commands.
- Uses the same tick-count endpoints and REVERSED convention as the generator, so a generator/decoder pair round-trips an angle to within quantisation error.

Parameters:
- TICKDIV, 488: system clocks per measurement tick. 1 = count every clock.
- SERVOMIN, 124: pulse width in ticks that maps to angle 0.
- SERVOMAX, 543: pulse width in ticks that maps to angle 4095. Must satisfy SERVOMAX > SERVOMIN and SERVOMAX < 4096.
- REVERSED, 0: when 1, output angle = 4095 - computed angle.
- TIMEOUT, 8192: ticks without a rising edge before the signal is declared lost.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  decoder runs when 1. When 0: FSM forced to IDLE, counters cleared, angle and lost hold their values.
- pwm_in  input  1  asynchronous PWM pulse from the pin.
- angle  output  12  last decoded angle code.
- valid  output  1  one-clock strobe when angle updates.
- lost  output  1  level; 1 while the signal is timed out.
- overrange  output  1  level; 1 if the last pulse was <= SERVOMIN or >= SERVOMAX ticks (clamped). Cleared by the next in-range pulse.

Behaviour:
- Reset (reset=0, asynchronous): angle=0, valid=0, lost=0, overrange=0, FSM=IDLE, sync flops=0, all counters=0.
- Input path:
  - pwm_in passes through a 2-flop synchroniser, then a registered copy for edge detection.
  - Rise/fall is detected 3 clocks after the pin edge.
- Tick generator:
  - Modulo-TICKDIV counter; tick=1 for one clock each wrap.
  - Free-running while enable=1; cleared on a rising edge so width quantisation starts aligned.
- FSM states IDLE, ARMED, MEASURE, DIVIDE, OUTPUT:
  - IDLE: wait for synchronised input low (discards a partial first pulse); go to ARMED.
  - ARMED: on rising edge, clear the width counter and go to MEASURE.
  - MEASURE: width += 1 on each tick while high. Width counter saturates at 4095. On falling edge, latch width and go to DIVIDE.
  - DIVIDE: exactly 12 clocks of restoring division (one quotient bit per clock, MSB first).
    - Dividend = (width - SERVOMIN) * 4095, 21 bits unsigned.
    - Divisor = SERVOMAX - SERVOMIN.
    - Quotient is floored (no rounding).
    - If width <= SERVOMIN, dividend is forced to 0. If width >= SERVOMAX, the quotient is forced to 4095 at the end.
    - In both clamp cases overrange is set; otherwise it is cleared.
    - Always 12 clocks, regardless of clamping.
  - OUTPUT: register angle (REVERSED applied), pulse valid=1 for one clock, clear lost, return to ARMED.
- Latency: valid rises exactly 17 clocks after the pin falling edge (3 detect + 1 latch + 12 divide + 1 output).
- A rising edge arriving during DIVIDE/OUTPUT is ignored. The next measurement starts at the following rising edge.
- Timeout:
  - A separate tick counter is cleared on every rising edge.
  - When it reaches TIMEOUT: lost=1, FSM returns to IDLE, no valid pulse is produced, angle holds.
  - A pulse stuck high for TIMEOUT ticks is also lost.
- enable 1->0 mid-pulse: the measurement is aborted, no valid; restart goes through IDLE.
- Reset asserted mid-measurement or mid-division: immediate return to reset values, no valid.

Test Plan:
- TICKDIV=1, after reset: drive 334-clock high pulse, 4000-clock low -> valid once, 17 clocks after falling edge; angle=2052, overrange=0.
- TICKDIV=1: pulses of 124 and 543 clocks -> angle=0 then 4095; overrange=1 both times. Then pulse of 200 -> angle=(76*4095)/419=742, overrange=0.
- TICKDIV=1, REVERSED=1: 334-clock pulse -> angle=2043. Pulses of 100 and 600 clocks -> angle=4095 then 0; overrange=1.
- TICKDIV=1, TIMEOUT=8192: hold pwm_in low 9000 clocks -> lost=1 at tick 8192, no valid, angle unchanged. Then 334-clock pulse -> valid, angle=2052, lost=0.
- Start stimulus with pwm_in already high at reset release -> that partial pulse produces no valid; the next full pulse decodes correctly.
- Assert reset (0) for 2 clocks mid-MEASURE and separately mid-DIVIDE -> angle=0, valid never pulses for that pulse. Deassert enable mid-pulse -> no valid, angle holds previous value.
